// File: rtl/timebase_timer.sv
// Microsecond timebase with a free-running timestamp and NUM_CH countdown channels.
// Define TIMEBASE_TIMER_MS_EN to add the millisecond tick and timestamp outputs.
module timebase_timer #(
    parameter int CLK_FREQ_MHZ = 50,
    parameter int WIDTH        = 32,
    parameter int NUM_CH       = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    output logic                    tick_us,
    output logic [WIDTH-1:0]        time_us,
    input  logic [NUM_CH-1:0]       ch_start,
    input  logic [NUM_CH-1:0]       ch_stop,
    input  logic [NUM_CH-1:0]       ch_periodic,
    input  logic [NUM_CH*WIDTH-1:0] ch_load,
    output logic [NUM_CH-1:0]       ch_busy,
    output logic [NUM_CH-1:0]       ch_expire
`ifdef TIMEBASE_TIMER_MS_EN
    ,
    output logic                    tick_ms,
    output logic [WIDTH-1:0]        time_ms
`endif
);

    localparam int PW = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;

    logic [PW-1:0] presc;
    logic          tick_q;
    logic          tick_evt;

    // tick_evt marks the edge on which time_us advances and channels count down;
    // tick_us is its registered image, so both become visible in the same cycle.
    assign tick_evt = enable && (presc == PW'(CLK_FREQ_MHZ - 1));
    assign tick_us  = tick_q & enable;

    always_ff @(posedge clk) begin
        if (rst) begin
            presc   <= '0;
            tick_q  <= 1'b0;
            time_us <= '0;
        end else begin
            tick_q <= tick_evt;
            if (enable) begin
                presc <= tick_evt ? '0 : presc + PW'(1);
            end
            if (tick_evt) begin
                time_us <= time_us + WIDTH'(1);
            end
        end
    end

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } ch_state_t;

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        ch_state_t        state, state_nx;
        logic [WIDTH-1:0] rem, rem_nx;
        logic [WIDTH-1:0] period, period_nx;
        logic             mode, mode_nx;
        logic             exp_r, exp_nx;
        logic [WIDTH-1:0] load;

        assign load         = ch_load[n*WIDTH +: WIDTH];
        assign ch_busy[n]   = (state == CH_RUN);
        assign ch_expire[n] = exp_r;

        always_ff @(posedge clk) begin
            if (rst) begin
                state  <= CH_IDLE;
                rem    <= '0;
                period <= '0;
                mode   <= 1'b0;
                exp_r  <= 1'b0;
            end else begin
                state  <= state_nx;
                rem    <= rem_nx;
                period <= period_nx;
                mode   <= mode_nx;
                exp_r  <= exp_nx;
            end
        end

        // Priority: stop, then start (which swallows a coincident tick), then countdown.
        always_comb begin
            state_nx  = state;
            rem_nx    = rem;
            period_nx = period;
            mode_nx   = mode;
            exp_nx    = 1'b0;
            if (ch_stop[n]) begin
                state_nx = CH_IDLE;
                rem_nx   = '0;
            end else if (ch_start[n]) begin
                if (load != '0) begin
                    state_nx  = CH_RUN;
                    rem_nx    = load;
                    period_nx = load;
                    mode_nx   = ch_periodic[n];
                end else begin
                    state_nx = CH_IDLE;
                    rem_nx   = '0;
                    exp_nx   = 1'b1;
                end
            end else if (state == CH_RUN && tick_evt) begin
                if (rem == WIDTH'(1)) begin
                    exp_nx = 1'b1;
                    if (mode) begin
                        rem_nx = period;
                    end else begin
                        state_nx = CH_IDLE;
                        rem_nx   = '0;
                    end
                end else begin
                    rem_nx = rem - WIDTH'(1);
                end
            end
        end
    end

`ifdef TIMEBASE_TIMER_MS_EN
    logic [9:0] ms_presc;
    logic       ms_tick_q;
    logic       ms_evt;

    assign ms_evt  = tick_evt && (ms_presc == 10'd999);
    assign tick_ms = ms_tick_q & enable;

    always_ff @(posedge clk) begin
        if (rst) begin
            ms_presc  <= '0;
            ms_tick_q <= 1'b0;
            time_ms   <= '0;
        end else begin
            ms_tick_q <= ms_evt;
            if (tick_evt) begin
                ms_presc <= ms_evt ? '0 : ms_presc + 10'd1;
            end
            if (ms_evt) begin
                time_ms <= time_ms + WIDTH'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_timebase_timer.sv
// Self-checking bench for timebase_timer: tick rate, channel modes, freeze, wrap and reset.
// A cycle model of the prescaler predicts ticks; expected expiry tick numbers go through exp_q.
module tb_timebase_timer;

    localparam int CLK_MHZ = 50;
    localparam int W       = 8;
    localparam int NCH     = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             enable;
    logic [NCH-1:0]   ch_start;
    logic [NCH-1:0]   ch_stop;
    logic [NCH-1:0]   ch_periodic;
    logic [NCH*W-1:0] ch_load;
    logic             tick_us;
    logic [W-1:0]     time_us;
    logic [NCH-1:0]   ch_busy;
    logic [NCH-1:0]   ch_expire;

`ifdef TIMEBASE_TIMER_MS_EN
    logic         tick_ms;
    logic [W-1:0] time_ms;
    logic         ms_en = 1'b1;
    logic [0:0]   ms_zero1 = 1'b0;
    logic [W-1:0] ms_zero_load = '0;
    logic         ms_tick_us;
    logic [W-1:0] ms_time_us;
    logic [0:0]   ms_busy;
    logic [0:0]   ms_expire;
    logic         ms_tick_ms;
    logic [W-1:0] ms_time_ms;
`endif

    timebase_timer #(.CLK_FREQ_MHZ(CLK_MHZ), .WIDTH(W), .NUM_CH(NCH)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .tick_us(tick_us), .time_us(time_us),
        .ch_start(ch_start), .ch_stop(ch_stop), .ch_periodic(ch_periodic),
        .ch_load(ch_load), .ch_busy(ch_busy), .ch_expire(ch_expire)
`ifdef TIMEBASE_TIMER_MS_EN
        , .tick_ms(tick_ms), .time_ms(time_ms)
`endif
    );

`ifdef TIMEBASE_TIMER_MS_EN
    timebase_timer #(.CLK_FREQ_MHZ(2), .WIDTH(W), .NUM_CH(1)) dut_ms (
        .clk(clk), .rst(rst), .enable(ms_en),
        .tick_us(ms_tick_us), .time_us(ms_time_us),
        .ch_start(ms_zero1), .ch_stop(ms_zero1), .ch_periodic(ms_zero1),
        .ch_load(ms_zero_load), .ch_busy(ms_busy), .ch_expire(ms_expire),
        .tick_ms(ms_tick_ms), .time_ms(ms_time_ms)
    );
`endif

    int          checks = 0;
    int          errors = 0;
    int          ph     = 0;
    int          mticks = 0;
    logic [W-1:0] mtime = '0;
    logic        exp_tick = 1'b0;
    logic [31:0] exp_q[$];

    // One clock: inputs are sampled at the edge, outputs read 1 time unit later;
    // the prescaler model advances alongside.
    task automatic step();
        logic en, r;
        en = enable;
        r  = rst;
        @(posedge clk);
        #1;
        if (r) begin
            ph = 0; mtime = '0; exp_tick = 1'b0;
        end else if (en) begin
            if (ph == CLK_MHZ - 1) begin
                ph = 0; mtime = mtime + 1'b1; mticks++; exp_tick = 1'b1;
            end else begin
                ph++; exp_tick = 1'b0;
            end
        end else begin
            exp_tick = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0;
        ch_start = '0; ch_stop = '0; ch_periodic = '0; ch_load = '0;
        repeat (3) step();
        checks++; if (tick_us !== 1'b0) begin errors++; $display("FAIL reset_tick got %0d expected 0", tick_us); end
        checks++; if (time_us !== '0) begin errors++; $display("FAIL reset_time got %0d expected 0", time_us); end
        checks++; if (ch_busy !== '0) begin errors++; $display("FAIL reset_busy got %b expected 0", ch_busy); end
        checks++; if (ch_expire !== '0) begin errors++; $display("FAIL reset_expire got %b expected 0", ch_expire); end
        rst = 1'b0; enable = 1'b1;
    endtask

    task automatic test_tick_rate();
        logic [31:0] e;
        exp_q.delete();
        for (int k = 1; k <= 10; k++) exp_q.push_back(32'(k * CLK_MHZ));
        for (int i = 1; i <= 10 * CLK_MHZ; i++) begin
            step();
            if (tick_us) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL tick_rate extra pulse at cycle %0d", i);
                end else begin
                    e = exp_q.pop_front();
                    if (i !== e) begin errors++; $display("FAIL tick_rate pulse at cycle %0d expected %0d", i, e); end
                end
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL tick_count missing %0d pulses expected 0", exp_q.size()); end
        checks++; if (time_us !== 8'd10) begin errors++; $display("FAIL tick_time got %0d expected 10", time_us); end
    endtask

    task automatic test_oneshot();
        logic [31:0] e;
        exp_q.delete();
        ch_load[0 +: W] = 8'd3; ch_periodic[0] = 1'b0; ch_start[0] = 1'b1;
        step();
        ch_start[0] = 1'b0;
        exp_q.push_back(32'(mticks + 3));
        checks++; if (ch_busy[0] !== 1'b1) begin errors++; $display("FAIL oneshot_busy got %0d expected 1", ch_busy[0]); end
        for (int i = 0; i < 5 * CLK_MHZ; i++) begin
            step();
            if (ch_expire[0]) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL oneshot_expire extra pulse at tick %0d", mticks);
                end else begin
                    e = exp_q.pop_front();
                    if (mticks !== e || tick_us !== 1'b1) begin
                        errors++; $display("FAIL oneshot_expire got tick %0d expected %0d", mticks, e);
                    end
                end
                checks++; if (ch_busy[0] !== 1'b0) begin errors++; $display("FAIL oneshot_idle got %0d expected 0", ch_busy[0]); end
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL oneshot_missing got %0d pending expected 0", exp_q.size()); end
        checks++; if (ch_busy[0] !== 1'b0) begin errors++; $display("FAIL oneshot_end_busy got %0d expected 0", ch_busy[0]); end
    endtask

    task automatic test_periodic();
        logic [31:0] e;
        int s, pulses;
        exp_q.delete();
        ch_load[W +: W] = 8'd2; ch_periodic[1] = 1'b1; ch_start[1] = 1'b1;
        step();
        ch_start[1] = 1'b0;
        s = mticks;
        for (int k = 1; k <= 5; k++) exp_q.push_back(32'(s + 2 * k));
        for (int i = 0; i < 12 * CLK_MHZ && mticks < s + 10; i++) begin
            step();
            if (ch_expire[1]) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL periodic_expire extra pulse at tick %0d", mticks);
                end else begin
                    e = exp_q.pop_front();
                    if (mticks !== e) begin errors++; $display("FAIL periodic_expire got tick %0d expected %0d", mticks, e); end
                end
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL periodic_count missing %0d pulses expected 0", exp_q.size()); end

        ch_start[1] = 1'b1;
        step();
        ch_start[1] = 1'b0;
        s = mticks;
        for (int k = 1; k <= 3; k++) exp_q.push_back(32'(s + 2 * k));
        for (int i = 0; i < 8 * CLK_MHZ && mticks < s + 6; i++) begin
            step();
            if (ch_expire[1]) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL periodic_restart extra pulse at tick %0d", mticks);
                end else begin
                    e = exp_q.pop_front();
                    if (mticks !== e) begin errors++; $display("FAIL periodic_restart got tick %0d expected %0d", mticks, e); end
                end
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL periodic_restart missing %0d pulses expected 0", exp_q.size()); end
        ch_stop[1] = 1'b1;
        step();
        ch_stop[1] = 1'b0;
        checks++; if (ch_busy[1] !== 1'b0) begin errors++; $display("FAIL stop_busy got %0d expected 0", ch_busy[1]); end
        pulses = 0;
        for (int i = 0; i < 6 * CLK_MHZ; i++) begin
            step();
            if (ch_expire[1]) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL stop_pulses got %0d expected 0", pulses); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        int s;
        exp_q.delete();
        ch_load[0 +: W] = 8'd3; ch_periodic[0] = 1'b0; ch_start[0] = 1'b1;
        step();
        ch_start[0] = 1'b0;
        s = mticks;
        for (int i = 0; i < 2 * CLK_MHZ && mticks < s + 1; i++) step();
        ch_start[0] = 1'b1;
        step();
        ch_start[0] = 1'b0;
        s = mticks;
        exp_q.push_back(32'(s + 3));
        for (int i = 0; i < 5 * CLK_MHZ && mticks < s + 4; i++) begin
            step();
            if (ch_expire[0]) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL restart_expire extra pulse at tick %0d", mticks);
                end else begin
                    e = exp_q.pop_front();
                    if (mticks !== e) begin errors++; $display("FAIL restart_expire got tick %0d expected %0d", mticks, e); end
                end
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL restart_missing got %0d pending expected 0", exp_q.size()); end

        // Land a start on the same edge as a tick: the tick must not count.
        for (int i = 0; i < 2 * CLK_MHZ && ph != CLK_MHZ - 1; i++) step();
        ch_load[0 +: W] = 8'd4; ch_start[0] = 1'b1;
        step();
        ch_start[0] = 1'b0;
        checks++; if (tick_us !== 1'b1) begin errors++; $display("FAIL coincide_tick got %0d expected 1", tick_us); end
        s = mticks;
        exp_q.push_back(32'(s + 4));
        for (int i = 0; i < 6 * CLK_MHZ && mticks < s + 5; i++) begin
            step();
            if (ch_expire[0]) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL coincide_expire extra pulse at tick %0d", mticks);
                end else begin
                    e = exp_q.pop_front();
                    if (mticks !== e) begin errors++; $display("FAIL coincide_expire got tick %0d expected %0d", mticks, e); end
                end
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL coincide_missing got %0d pending expected 0", exp_q.size()); end
    endtask

    task automatic test_zero_load();
        ch_load[2*W +: W] = 8'd5; ch_periodic[2] = 1'b1; ch_start[2] = 1'b1;
        step();
        checks++; if (ch_busy[2] !== 1'b1) begin errors++; $display("FAIL zero_pre_busy got %0d expected 1", ch_busy[2]); end
        ch_load[2*W +: W] = 8'd0;
        step();
        ch_start[2] = 1'b0;
        checks++; if (ch_expire[2] !== 1'b1) begin errors++; $display("FAIL zero_expire got %0d expected 1", ch_expire[2]); end
        checks++; if (ch_busy[2] !== 1'b0) begin errors++; $display("FAIL zero_busy got %0d expected 0", ch_busy[2]); end
        step();
        checks++; if (ch_expire[2] !== 1'b0) begin errors++; $display("FAIL zero_once got %0d expected 0", ch_expire[2]); end
    endtask

    task automatic test_freeze();
        logic [31:0] e;
        logic [W-1:0] frozen;
        int s, pulses;
        exp_q.delete();
        ch_load[2*W +: W] = 8'd5; ch_periodic[2] = 1'b0; ch_start[2] = 1'b1;
        step();
        ch_start[2] = 1'b0;
        s = mticks;
        exp_q.push_back(32'(s + 5));
        for (int i = 0; i < 3 * CLK_MHZ && mticks < s + 2; i++) step();
        repeat (20) step();
        frozen = mtime;
        enable = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            checks++;
            if (tick_us !== 1'b0 || time_us !== frozen || ch_expire !== '0) begin
                errors++; $display("FAIL freeze got tick %0d time %0d expire %b expected 0 %0d 0", tick_us, time_us, ch_expire, frozen);
            end
        end
        checks++; if (ch_busy[2] !== 1'b1) begin errors++; $display("FAIL freeze_busy got %0d expected 1", ch_busy[2]); end
        enable = 1'b1;
        for (int i = 0; i < 5 * CLK_MHZ && mticks < s + 6; i++) begin
            step();
            if (ch_expire[2]) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL freeze_expire extra pulse at tick %0d", mticks);
                end else begin
                    e = exp_q.pop_front();
                    if (mticks !== e) begin errors++; $display("FAIL freeze_expire got tick %0d expected %0d", mticks, e); end
                end
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL freeze_missing got %0d pending expected 0", exp_q.size()); end
        checks++; if (time_us !== mtime) begin errors++; $display("FAIL freeze_time got %0d expected %0d", time_us, mtime); end

        ch_load[3*W +: W] = 8'd4; ch_periodic[3] = 1'b1; ch_start[3] = 1'b1;
        step();
        checks++; if (ch_busy[3] !== 1'b1) begin errors++; $display("FAIL startstop_pre got %0d expected 1", ch_busy[3]); end
        ch_stop[3] = 1'b1;
        step();
        ch_start[3] = 1'b0; ch_stop[3] = 1'b0;
        checks++; if (ch_busy[3] !== 1'b0) begin errors++; $display("FAIL startstop_busy got %0d expected 0", ch_busy[3]); end
        pulses = 0;
        for (int i = 0; i < 5 * CLK_MHZ; i++) begin
            step();
            if (ch_expire[3]) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL startstop_pulses got %0d expected 0", pulses); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 260 * CLK_MHZ && mtime != 8'd255; i++) step();
        checks++; if (time_us !== 8'd255) begin errors++; $display("FAIL wrap_pre got %0d expected 255", time_us); end
        step();
        for (int i = 0; i < 2 * CLK_MHZ && !exp_tick; i++) step();
        checks++; if (time_us !== 8'd0) begin errors++; $display("FAIL wrap_time got %0d expected 0", time_us); end
        checks++; if (tick_us !== 1'b1) begin errors++; $display("FAIL wrap_tick got %0d expected 1", tick_us); end
    endtask

    task automatic test_reset_run();
        int pulses;
        ch_load[0 +: W] = 8'd10; ch_load[W +: W] = 8'd10;
        ch_periodic[0] = 1'b0; ch_periodic[1] = 1'b1;
        ch_start[1:0] = 2'b11;
        step();
        ch_start[1:0] = 2'b00;
        checks++; if (ch_busy[1:0] !== 2'b11) begin errors++; $display("FAIL rrun_busy got %b expected 11", ch_busy[1:0]); end
        repeat (100) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (tick_us !== 1'b0 || time_us !== '0) begin errors++; $display("FAIL rrun_time got tick %0d time %0d expected 0 0", tick_us, time_us); end
        checks++; if (ch_busy !== '0 || ch_expire !== '0) begin errors++; $display("FAIL rrun_ch got busy %b expire %b expected 0 0", ch_busy, ch_expire); end
        pulses = 0;
        for (int i = 0; i < 20 * CLK_MHZ; i++) begin
            step();
            if (ch_expire != '0) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL rrun_pulses got %0d expected 0", pulses); end
        checks++; if (time_us !== 8'd20) begin errors++; $display("FAIL rrun_after got %0d expected 20", time_us); end
    endtask

`ifdef TIMEBASE_TIMER_MS_EN
    task automatic test_ms();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (3999) step();
        checks++; if (ms_time_ms !== 8'd1) begin errors++; $display("FAIL ms_pre got %0d expected 1", ms_time_ms); end
        step();
        checks++; if (ms_time_ms !== 8'd2 || ms_tick_ms !== 1'b1) begin
            errors++; $display("FAIL ms_time got %0d tick %0d expected 2 1", ms_time_ms, ms_tick_ms);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_tick_rate();
        test_oneshot();
        test_periodic();
        test_back_to_back();
        test_zero_load();
        test_freeze();
        test_wrap();
        test_reset_run();
`ifdef TIMEBASE_TIMER_MS_EN
        test_ms();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
